// File: rtl/display_scan_controller.sv
// rtl/display_scan_controller.sv - 4-digit seven-segment scan controller with double-buffered segment store
module display_scan_controller #(
   parameter int DIV_MAX   = 100000,
   parameter int DIV_WIDTH = 17
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       disp_en,
   input  logic [3:0] bright,
   input  logic       wr_valid,
   input  logic [1:0] wr_addr,
   input  logic [6:0] wr_data,
   output logic       wr_ready,
   input  logic       commit,
   output logic       frame_done,
   output logic [3:0] an,
   output logic [6:0] sseg
);

   localparam logic [DIV_WIDTH-1:0] DIV_LAST = DIV_WIDTH'(DIV_MAX - 1);

   logic [DIV_WIDTH-1:0] div_cnt;
   logic [1:0]           digit;
   logic [3:0]           pwm_cnt;
   logic                 pending;
   logic [6:0]           shadow [4];
   logic [6:0]           front  [4];

   logic slot_end;
   logic frame_end;
   logic pwm_on;
   logic wr_fire;
   logic commit_fire;

   assign slot_end    = (div_cnt == DIV_LAST);
   assign frame_end   = slot_end && (digit == 2'b11);
   assign pwm_on      = (pwm_cnt <= bright);
   assign wr_ready    = ~pending;
   assign wr_fire     = wr_valid && wr_ready;
   assign commit_fire = commit && wr_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt    <= '0;
         digit      <= 2'b00;
         pwm_cnt    <= 4'd0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         an         <= 4'b1111;
         sseg       <= 7'h7F;
         for (int i = 0; i < 4; i++) begin
            shadow[i] <= 7'h7F;
            front[i]  <= 7'h7F;
         end
      end else begin
         div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
         if (slot_end)
            digit <= digit + 2'd1;
         pwm_cnt <= pwm_cnt + 4'd1;

         if (wr_fire)
            shadow[wr_addr] <= wr_data;

         // Pending must already be set before the boundary edge; a commit landing
         // on the boundary cycle waits for the next frame.
         if (frame_end && pending) begin
            for (int i = 0; i < 4; i++)
               front[i] <= shadow[i];
            pending <= 1'b0;
         end else if (commit_fire) begin
            pending <= 1'b1;
         end

         frame_done <= frame_end;
         an         <= (disp_en && pwm_on) ? ~(4'b0001 << digit) : 4'b1111;
         sseg       <= disp_en ? front[digit] : 7'h7F;
      end
   end

endmodule

// File: tb/tb_display_scan_controller.sv
// tb/tb_display_scan_controller.sv - table-driven bench for display_scan_controller
module tb_display_scan_controller;

   typedef struct {
      logic       wv;
      logic [1:0] wa;
      logic [6:0] wd;
      logic       cm;
      logic [3:0] e_an;
      logic [6:0] e_sseg;
      logic       e_fd;
      logic       e_rdy;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       disp_en;
   logic [3:0] bright;
   logic       wr_valid;
   logic [1:0] wr_addr;
   logic [6:0] wr_data;
   logic       commit;
   logic       wr_ready, frame_done;
   logic [3:0] an;
   logic [6:0] sseg;
   logic       wr_ready2, frame_done2;
   logic [3:0] an2;
   logic [6:0] sseg2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   display_scan_controller #(.DIV_MAX(4), .DIV_WIDTH(17)) dut (
      .clk(clk), .reset(reset), .disp_en(disp_en), .bright(bright),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
      .commit(commit), .frame_done(frame_done), .an(an), .sseg(sseg)
   );

   display_scan_controller #(.DIV_MAX(16), .DIV_WIDTH(17)) dut16 (
      .clk(clk), .reset(reset), .disp_en(disp_en), .bright(bright),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready2),
      .commit(commit), .frame_done(frame_done2), .an(an2), .sseg(sseg2)
   );

   task automatic chk(input string name, input int n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s n=%0d got %h want %h", name, n, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   vec_t       vt [80];
   logic [3:0] oc [4];
   logic [6:0] f1 [4];
   logic [6:0] f2 [4];
   logic [6:0] f4 [4];
   int         d, f, active;

   initial begin
      oc = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
      f1 = '{7'h40, 7'h79, 7'h24, 7'h30};
      f2 = '{7'h40, 7'h12, 7'h24, 7'h30};
      f4 = '{7'h40, 7'h12, 7'h55, 7'h30};

      // Row n-1 holds the inputs applied at edge n and the outputs expected just after it.
      for (int n = 1; n <= 80; n++) begin
         d = ((n - 1) / 4) % 4;
         f = (n - 1) / 16;
         vt[n-1].wv     = 1'b0;
         vt[n-1].wa     = 2'd0;
         vt[n-1].wd     = 7'h00;
         vt[n-1].cm     = 1'b0;
         vt[n-1].e_an   = oc[d];
         vt[n-1].e_fd   = (n % 16 == 0);
         vt[n-1].e_rdy  = !((n >= 6 && n <= 15) || (n >= 20 && n <= 31) || (n >= 48 && n <= 63));
         case (f)
            0:       vt[n-1].e_sseg = 7'h7F;
            1:       vt[n-1].e_sseg = f1[d];
            2, 3:    vt[n-1].e_sseg = f2[d];
            default: vt[n-1].e_sseg = f4[d];
         endcase
      end
      for (int a = 0; a < 4; a++) begin
         vt[a+1].wv = 1'b1;
         vt[a+1].wa = 2'(a);
         vt[a+1].wd = f1[a];
      end
      vt[5].cm  = 1'b1;
      vt[7].wv  = 1'b1; vt[7].wa  = 2'd0; vt[7].wd  = 7'h00; vt[7].cm  = 1'b1;
      vt[19].wv = 1'b1; vt[19].wa = 2'd1; vt[19].wd = 7'h12; vt[19].cm = 1'b1;
      vt[47].wv = 1'b1; vt[47].wa = 2'd2; vt[47].wd = 7'h55; vt[47].cm = 1'b1;

      reset    = 1'b1;
      disp_en  = 1'b1;
      bright   = 4'd15;
      wr_valid = 1'b0;
      wr_addr  = 2'd0;
      wr_data  = 7'h00;
      commit   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_an",    0, 32'(an),         32'hF);
      chk("reset_sseg",  0, 32'(sseg),       32'h7F);
      chk("reset_fd",    0, 32'(frame_done), 32'h0);
      chk("reset_rdy",   0, 32'(wr_ready),   32'h1);
      reset = 1'b0;

      for (int n = 1; n <= 80; n++) begin
         wr_valid = vt[n-1].wv;
         wr_addr  = vt[n-1].wa;
         wr_data  = vt[n-1].wd;
         commit   = vt[n-1].cm;
         step();
         chk("an",    n, 32'(an),         32'(vt[n-1].e_an));
         chk("sseg",  n, 32'(sseg),       32'(vt[n-1].e_sseg));
         chk("fd",    n, 32'(frame_done), 32'(vt[n-1].e_fd));
         chk("rdy",   n, 32'(wr_ready),   32'(vt[n-1].e_rdy));
      end
      wr_valid = 1'b0;
      commit   = 1'b0;

      // bright=3 on the 16-cycle-slot instance: slot for digit 1 spans edges 81..96
      bright = 4'd3;
      active = 0;
      for (int n = 81; n <= 96; n++) begin
         step();
         chk("bright_an", n, 32'(an2), (n - 81 < 4) ? 32'hD : 32'hF);
         if (an2 != 4'hF)
            active++;
      end
      chk("bright_active_cnt", 96, 32'(active), 32'd4);

      bright  = 4'd15;
      disp_en = 1'b0;
      step();
      chk("disp_off_an",   97, 32'(an),   32'hF);
      chk("disp_off_sseg", 97, 32'(sseg), 32'h7F);

      disp_en  = 1'b1;
      wr_valid = 1'b1;
      wr_addr  = 2'd0;
      wr_data  = 7'h00;
      commit   = 1'b1;
      step();
      wr_valid = 1'b0;
      commit   = 1'b0;
      chk("pend_rdy", 98, 32'(wr_ready), 32'h0);
      #2;
      reset = 1'b1;
      #1;
      chk("async_an",   98, 32'(an),         32'hF);
      chk("async_sseg", 98, 32'(sseg),       32'h7F);
      chk("async_rdy",  98, 32'(wr_ready),   32'h1);
      chk("async_fd",   98, 32'(frame_done), 32'h0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int n = 1; n <= 17; n++) begin
         step();
         chk("post_rst_sseg", n, 32'(sseg),     32'h7F);
         chk("post_rst_rdy",  n, 32'(wr_ready), 32'h1);
         if (n == 16)
            chk("post_rst_fd", n, 32'(frame_done), 32'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
